// File: rtl/heap_op_issue_queue_if.sv
// ============================================================================
// Module : heap_op_issue_queue_if
// Brief  : Request, C3 issue/return and completion signals of the heap issue queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface heap_op_issue_queue_if;
    logic        req_v;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_rd;
    logic [31:0] req_data;

    logic        c3_in_v;
    logic [4:0]  c3_rd;
    logic [2:0]  c3_vrd1;
    logic [31:0] c3_in_data;
    logic        c3_out_v;
    logic [4:0]  c3_out_rd;
    logic [31:0] c3_out_data;

    logic        cmp_v;
    logic [4:0]  cmp_rd;
    logic [31:0] cmp_data;
    logic        cmp_err;

    // Issue-queue side.
    modport slave (
        input  req_v, req_op, req_rd, req_data,
        input  c3_out_v, c3_out_rd, c3_out_data,
        output req_ready,
        output c3_in_v, c3_rd, c3_vrd1, c3_in_data,
        output cmp_v, cmp_rd, cmp_data, cmp_err
    );

    // Core decode / C3 unit / writeback side.
    modport master (
        output req_v, req_op, req_rd, req_data,
        output c3_out_v, c3_out_rd, c3_out_data,
        input  req_ready,
        input  c3_in_v, c3_rd, c3_vrd1, c3_in_data,
        input  cmp_v, cmp_rd, cmp_data, cmp_err
    );
endinterface

`default_nettype wire

// File: rtl/heap_op_issue_queue.sv
// ============================================================================
// Module : heap_op_issue_queue
// Brief  : Command FIFO plus single-outstanding issue FSM for the C3 heap unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module heap_op_issue_queue #(
    parameter int DEPTH       = 4,
    parameter int PIPE_CYCLES = 5,
    parameter int HEAP_SIZE   = 256
) (
    input  wire logic             clk,
    input  wire logic             reset,
    heap_op_issue_queue_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(HEAP_SIZE + 1);
    localparam int WAIT_W = $clog2(PIPE_CYCLES + 2);

    localparam logic [2:0]        C_OP_PUSH   = 3'd1;
    localparam logic [2:0]        C_OP_POP    = 3'd2;
    localparam logic [CNT_W-1:0]  C_CNT_MAX   = CNT_W'(HEAP_SIZE);
    localparam logic [WAIT_W-1:0] C_WAIT_LOAD = WAIT_W'(PIPE_CYCLES + 1);
    localparam logic [PTR_W:0]    C_FILL_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ---------------- command FIFO ----------------
    logic [2:0]  op_mem_q   [DEPTH];
    logic [4:0]  rd_mem_q   [DEPTH];
    logic [31:0] data_mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   fill_q;

    state_t state_q, state_d;

    logic w_empty, w_full, w_ready, w_enq, w_deq;
    logic [2:0]  w_head_op;
    logic [4:0]  w_head_rd;
    logic [31:0] w_head_data;

    assign w_empty = (fill_q == '0);
    assign w_full  = (fill_q == C_FILL_FULL);
    // In IDLE a non-empty FIFO always dequeues this cycle, so a full FIFO can still accept.
    assign w_ready = !w_full || (state_q == ST_IDLE);
    assign w_enq   = bus.req_v && w_ready;
    assign w_deq   = (state_q == ST_IDLE) && !w_empty;

    assign w_head_op   = op_mem_q[rd_ptr_q];
    assign w_head_rd   = rd_mem_q[rd_ptr_q];
    assign w_head_data = data_mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (w_enq) begin
            op_mem_q[wr_ptr_q]   <= bus.req_op;
            rd_mem_q[wr_ptr_q]   <= bus.req_rd;
            data_mem_q[wr_ptr_q] <= bus.req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (w_enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({w_enq, w_deq})
                2'b10:   fill_q <= fill_q + (PTR_W + 1)'(1);
                2'b01:   fill_q <= fill_q - (PTR_W + 1)'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // ---------------- issue FSM ----------------
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [4:0]  tag_q, tag_d;
    logic [2:0]  op_q, op_d;
    logic        rej_q, rej_d;
    logic        got_q, got_d;
    logic [31:0] res_q, res_d;
    logic        c3_in_v_q, c3_in_v_d;
    logic [4:0]  c3_rd_q, c3_rd_d;
    logic [2:0]  c3_op_q, c3_op_d;
    logic [31:0] c3_data_q, c3_data_d;
    logic        w_head_legal;

    assign w_head_legal = ((w_head_op == C_OP_PUSH) && (cnt_q != C_CNT_MAX)) ||
                          ((w_head_op == C_OP_POP)  && (cnt_q != '0));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        tag_d     = tag_q;
        op_d      = op_q;
        rej_d     = rej_q;
        got_d     = got_q;
        res_d     = res_q;
        c3_in_v_d = 1'b0;
        c3_rd_d   = c3_rd_q;
        c3_op_d   = c3_op_q;
        c3_data_d = c3_data_q;
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    tag_d = w_head_rd;
                    op_d  = w_head_op;
                    got_d = 1'b0;
                    res_d = '0;
                    if (w_head_legal) begin
                        rej_d     = 1'b0;
                        c3_in_v_d = 1'b1;
                        c3_rd_d   = w_head_rd;
                        c3_op_d   = w_head_op;
                        c3_data_d = w_head_data;
                        cnt_d     = (w_head_op == C_OP_PUSH) ? cnt_q + CNT_W'(1)
                                                             : cnt_q - CNT_W'(1);
                        wait_d    = C_WAIT_LOAD;
                        state_d   = ST_WAIT;
                    end else begin
                        rej_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                wait_d = wait_q - WAIT_W'(1);
                if (bus.c3_out_v && (bus.c3_out_rd == tag_q)) begin
                    got_d = 1'b1;
                    res_d = bus.c3_out_data;
                end
                if (wait_q == WAIT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wait_q    <= '0;
            tag_q     <= '0;
            op_q      <= '0;
            rej_q     <= 1'b0;
            got_q     <= 1'b0;
            res_q     <= '0;
            c3_in_v_q <= 1'b0;
            c3_rd_q   <= '0;
            c3_op_q   <= '0;
            c3_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            tag_q     <= tag_d;
            op_q      <= op_d;
            rej_q     <= rej_d;
            got_q     <= got_d;
            res_q     <= res_d;
            c3_in_v_q <= c3_in_v_d;
            c3_rd_q   <= c3_rd_d;
            c3_op_q   <= c3_op_d;
            c3_data_q <= c3_data_d;
        end
    end

    // ---------------- outputs ----------------
    logic w_cmp_v;
    assign w_cmp_v = (state_q == ST_DONE);

    assign bus.req_ready  = w_ready;
    assign bus.c3_in_v    = c3_in_v_q;
    assign bus.c3_rd      = c3_rd_q;
    assign bus.c3_vrd1    = c3_op_q;
    assign bus.c3_in_data = c3_data_q;
    assign bus.cmp_v      = w_cmp_v;
    assign bus.cmp_rd     = w_cmp_v ? tag_q : 5'd0;
    assign bus.cmp_data   = (w_cmp_v && !rej_q && (op_q == C_OP_POP) && got_q) ? res_q : 32'd0;
    assign bus.cmp_err    = w_cmp_v && (rej_q || ((op_q == C_OP_POP) && !got_q));

endmodule

`default_nettype wire

// File: tb/tb_heap_op_issue_queue.sv
// ============================================================================
// Module : tb_heap_op_issue_queue
// Brief  : Directed bench for heap_op_issue_queue with a max-heap C3 pipeline model.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_heap_op_issue_queue;
    localparam int DEPTH = 4;
    localparam int PIPE  = 5;
    localparam int HSZ   = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    heap_op_issue_queue_if bus();

    heap_op_issue_queue #(
        .DEPTH(DEPTH), .PIPE_CYCLES(PIPE), .HEAP_SIZE(HSZ)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- C3 model: max-heap behind a PIPE-deep valid pipeline ----------------
    logic [31:0] heap_q[$];
    logic        p_v  [PIPE];
    logic [4:0]  p_rd [PIPE];
    logic [31:0] p_d  [PIPE];
    int          c3_mode = 0;   // 0 normal, 1 no result, 2 wrong tag

    function automatic logic [31:0] model_pop();
        int mi;
        logic [31:0] v;
        if (heap_q.size() == 0) return 32'd0;
        mi = 0;
        for (int i = 1; i < heap_q.size(); i++)
            if (heap_q[i] > heap_q[mi]) mi = i;
        v = heap_q[mi];
        heap_q.delete(mi);
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) p_v[i] <= 1'b0;
            heap_q.delete();
        end else begin
            p_v[0]  <= bus.c3_in_v;
            p_rd[0] <= bus.c3_rd;
            p_d[0]  <= 32'd0;
            if (bus.c3_in_v && bus.c3_vrd1 == 3'd1) heap_q.push_back(bus.c3_in_data);
            if (bus.c3_in_v && bus.c3_vrd1 == 3'd2) p_d[0] <= model_pop();
            for (int i = 1; i < PIPE; i++) begin
                p_v[i]  <= p_v[i-1];
                p_rd[i] <= p_rd[i-1];
                p_d[i]  <= p_d[i-1];
            end
        end
    end

    assign bus.c3_out_v    = p_v[PIPE-1] && (c3_mode != 1);
    assign bus.c3_out_rd   = (c3_mode == 2) ? (p_rd[PIPE-1] ^ 5'd1) : p_rd[PIPE-1];
    assign bus.c3_out_data = p_d[PIPE-1];

    // ---------------- completion / issue monitor ----------------
    int   cq_rd[$], cq_data[$], cq_err[$], cq_cyc[$];
    int   n_issue = 0;
    int   gap_viol = 0;
    logic prev_cmp = 1'b0;
    logic saw_nready = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            cq_rd.delete(); cq_data.delete(); cq_err.delete(); cq_cyc.delete();
            n_issue    = 0;
            saw_nready = 1'b0;
        end else begin
            if (bus.cmp_v) begin
                cq_rd.push_back(int'(bus.cmp_rd));
                cq_data.push_back(int'(bus.cmp_data));
                cq_err.push_back(int'(bus.cmp_err));
                cq_cyc.push_back(cyc);
            end
            if (bus.cmp_v && prev_cmp) gap_viol++;
            if (bus.c3_in_v) n_issue++;
            if (!bus.req_ready) saw_nready = 1'b1;
        end
        prev_cmp = bus.cmp_v;
    end

    // ---------------- helpers ----------------
    int rd_idx = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_c3_in_v", bus.c3_in_v, 0);
        chk("rst_c3_rd", bus.c3_rd, 0);
        chk("rst_c3_vrd1", bus.c3_vrd1, 0);
        chk("rst_c3_in_data", bus.c3_in_data, 0);
        chk("rst_cmp_v", bus.cmp_v, 0);
        chk("rst_cmp_rd", bus.cmp_rd, 0);
        chk("rst_cmp_data", bus.cmp_data, 0);
        chk("rst_cmp_err", bus.cmp_err, 0);
        reset   = 1'b0;
        rd_idx  = 0;
        c3_mode = 0;
    endtask

    // Presents a request and returns the index of the cycle whose closing edge accepted it.
    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] d,
                        output int acc);
        int b = 0;
        @(negedge clk);
        bus.req_v = 1'b1; bus.req_op = op; bus.req_rd = rd; bus.req_data = d;
        while (!bus.req_ready && b < 60) begin
            @(negedge clk);
            b++;
        end
        if (!bus.req_ready) begin
            chk("send_timeout", 1, 0);
            bus.req_v = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc - 1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_v = 1'b0;
    endtask

    task automatic get_cmp(input string tag, input int rd, input int data, input int err,
                           output int c);
        int b = 0;
        while (cq_rd.size() <= rd_idx && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (cq_rd.size() <= rd_idx) begin
            chk({tag, "_timeout"}, 0, 1);
            c = -1;
            return;
        end
        chk({tag, "_rd"},   cq_rd[rd_idx],   rd);
        chk({tag, "_data"}, cq_data[rd_idx], data);
        chk({tag, "_err"},  cq_err[rd_idx],  err);
        c = cq_cyc[rd_idx];
        rd_idx++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int a0, a1, a2, a3, c0, c1, tmp, b;
        int acc[6];
        bus.req_v = 1'b0; bus.req_op = 3'd0; bus.req_rd = 5'd0; bus.req_data = 32'd0;

        // Push ordering and pop returns max.
        do_reset();
        send(3'd1, 5'd1, 32'd5, a0);
        send(3'd1, 5'd2, 32'd9, a1);
        send(3'd1, 5'd3, 32'd2, a2);
        send(3'd2, 5'd4, 32'd0, a3);
        idle();
        get_cmp("t1_push1", 1, 0, 0, c0);
        chk("t1_first_latency", c0 - a0, 8);
        get_cmp("t1_push2", 2, 0, 0, c1);
        chk("t1_issue_spacing", c1 - c0, 8);
        get_cmp("t1_push3", 3, 0, 0, tmp);
        get_cmp("t1_pop", 4, 9, 0, tmp);

        // Pop on empty heap.
        do_reset();
        send(3'd2, 5'd7, 32'd0, a0);
        idle();
        get_cmp("t2_pop_empty", 7, 0, 1, c0);
        chk("t2_latency", c0 - a0, 2);
        chk("t2_no_issue", n_issue, 0);

        // Backpressure with held req_v; sixth push enters while full at a dequeue.
        do_reset();
        for (int i = 0; i < 6; i++) send(3'd1, 5'(i + 1), 32'(10 + i), acc[i]);
        idle();
        chk("t3_ready_dropped", saw_nready, 1);
        chk("t3_sixth_accept", acc[5] - acc[0], 9);
        for (int i = 0; i < 6; i++) get_cmp("t3_push", i + 1, 0, 0, tmp);
        for (int i = 0; i < 6; i++) send(3'd2, 5'(20 + i), 32'd0, tmp);
        send(3'd2, 5'd27, 32'd0, tmp);
        idle();
        for (int i = 0; i < 6; i++) get_cmp("t3_pop", 20 + i, 15 - i, 0, tmp);
        get_cmp("t3_pop_over", 27, 0, 1, tmp);
        chk("t3_issue_count", n_issue, 12);

        // Illegal opcode.
        do_reset();
        send(3'd3, 5'd12, 32'd99, a0);
        send(3'd1, 5'd13, 32'd77, tmp);
        send(3'd2, 5'd14, 32'd0, tmp);
        send(3'd2, 5'd15, 32'd0, tmp);
        idle();
        get_cmp("t4_illegal", 12, 0, 1, c0);
        chk("t4_reject_latency", c0 - a0, 2);
        get_cmp("t4_push", 13, 0, 0, tmp);
        get_cmp("t4_pop", 14, 77, 0, tmp);
        get_cmp("t4_pop_empty", 15, 0, 1, tmp);
        chk("t4_issue_count", n_issue, 2);

        // Reset while a pop waits on C3.
        do_reset();
        send(3'd1, 5'd1, 32'd40, tmp);
        send(3'd2, 5'd2, 32'd0, tmp);
        idle();
        get_cmp("t5_push", 1, 0, 0, tmp);
        b = 0;
        while (!bus.c3_in_v && b < 40) begin
            @(negedge clk);
            b++;
        end
        chk("t5_pop_issued", bus.c3_in_v, 1);
        repeat (2) @(negedge clk);
        do_reset();
        repeat (15) @(negedge clk);
        chk("t5_no_cmp_after_reset", cq_rd.size(), 0);
        send(3'd2, 5'd3, 32'd0, tmp);
        idle();
        get_cmp("t5_pop_after_reset", 3, 0, 1, tmp);
        chk("t5_no_issue", n_issue, 0);

        // Missing or mistagged C3 result.
        do_reset();
        c3_mode = 1;
        send(3'd1, 5'd5, 32'd3, tmp);
        send(3'd2, 5'd6, 32'd0, tmp);
        idle();
        get_cmp("t6_push", 5, 0, 0, tmp);
        get_cmp("t6_pop_missing", 6, 0, 1, tmp);
        c3_mode = 2;
        send(3'd1, 5'd8, 32'd4, tmp);
        send(3'd2, 5'd9, 32'd0, tmp);
        idle();
        get_cmp("t6_push_b", 8, 0, 0, tmp);
        get_cmp("t6_pop_badtag", 9, 0, 1, tmp);
        c3_mode = 0;
        send(3'd1, 5'd11, 32'd6, tmp);
        send(3'd2, 5'd12, 32'd0, tmp);
        idle();
        get_cmp("t6_push_c", 11, 0, 0, tmp);
        get_cmp("t6_pop_ok", 12, 6, 0, tmp);

        chk("cmp_never_back_to_back", gap_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
